// File: rtl/core_pkg.sv
// Core-wide shared types and constants used by the ROB allocator.
package CORE_PKG;

  // Total reorder-buffer entries and the width of a ROB index.
  localparam int unsigned NUM_ROB_ENTS   = 64;
  localparam int unsigned ROB_TAG_BITS   = $clog2(NUM_ROB_ENTS);

  // Width of the optional dispatch stall counter.
  localparam int unsigned STALL_CNT_BITS = 32;

  // Payload written into a ROB bank for each dispatched instruction.
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        exc;
  } ROB_Entry;

  // Allocator control states.
  typedef enum logic [1:0] {
    ROB_RUN,
    ROB_FULL,
    ROB_FLUSH
  } rob_state_e;

endpackage

// File: rtl/rob_bank_rotate.sv
// Lane-to-bank barrel rotation: lane i lands in bank (rot + i) mod DISPATCH_WIDTH.
module rob_bank_rotate
  import CORE_PKG::*;
#(
  parameter int unsigned DISPATCH_WIDTH = 2
) (
  input  logic [$clog2(DISPATCH_WIDTH)-1:0] rot_i,
  input  logic [DISPATCH_WIDTH-1:0]         lane_en_i,
  input  ROB_Entry [DISPATCH_WIDTH-1:0]     lane_data_i,
  output logic [DISPATCH_WIDTH-1:0]         bank_en_o,
  output ROB_Entry [DISPATCH_WIDTH-1:0]     bank_data_o
);

  localparam int unsigned ROT_W = $clog2(DISPATCH_WIDTH);

  logic [DISPATCH_WIDTH-1:0][ROT_W-1:0] src_idx;

  // Bank b is fed by lane (b - rot) mod DISPATCH_WIDTH; power-of-two width wraps for free.
  always_comb begin
    for (int unsigned b = 0; b < DISPATCH_WIDTH; b++) begin
      src_idx[b]     = ROT_W'(b) - rot_i;
      bank_en_o[b]   = lane_en_i[src_idx[b]];
      bank_data_o[b] = lane_data_i[src_idx[b]];
    end
  end

endmodule

// File: rtl/rob_alloc.sv
// ROB allocator: all-or-nothing group dispatch, tag assignment, bank routing,
// occupancy tracking with retire and flush.
// Optional feature: define ROB_ALLOC_STATS_EN to add the stall_cycles counter.
module rob_alloc
  import CORE_PKG::*;
#(
  parameter int unsigned DISPATCH_WIDTH = 2,
  parameter int unsigned NUM_ROB_ENTS   = CORE_PKG::NUM_ROB_ENTS
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [DISPATCH_WIDTH-1:0]                     disp_valid,
  input  ROB_Entry [DISPATCH_WIDTH-1:0]                 disp_entry,
  output logic                                          disp_ready,
  output logic [DISPATCH_WIDTH-1:0][ROB_TAG_BITS-1:0]   disp_tag,
  output logic [DISPATCH_WIDTH-1:0]                     bank_w_en,
  output ROB_Entry [DISPATCH_WIDTH-1:0]                 bank_data,
  input  logic [$clog2(DISPATCH_WIDTH):0]               retire_cnt,
  input  logic                                          flush,
  output logic                                          rob_full,
  output logic                                          rob_empty
`ifdef ROB_ALLOC_STATS_EN
  ,
  output logic [STALL_CNT_BITS-1:0]                     stall_cycles
`endif
);

  localparam int unsigned CNT_W = $clog2(DISPATCH_WIDTH) + 1;
  localparam int unsigned ROT_W = $clog2(DISPATCH_WIDTH);
  localparam int unsigned OCC_W = $clog2(NUM_ROB_ENTS + 1);
  localparam int unsigned TAG_W = ROB_TAG_BITS;
  // Headroom for tail + offset before the modulo fold.
  localparam int unsigned EW    = TAG_W + 2;

  rob_state_e              state_q, state_d;
  logic [TAG_W-1:0]        tail_q, tail_d;
  logic [OCC_W-1:0]        occ_q, occ_d;

  logic [CNT_W-1:0]        n;
  logic [CNT_W-1:0]        acc_n;
  logic [CNT_W-1:0]        ret_lim;
  logic [OCC_W-1:0]        ret_eff;
  logic [OCC_W-1:0]        free;
  logic [TAG_W-1:0]        head;
  logic [DISPATCH_WIDTH-1:0] lane_en;

  // Fold a sum in [0, 2*NUM_ROB_ENTS) back into the index range.
  function automatic logic [TAG_W-1:0] wrap_idx(input logic [EW-1:0] s);
    logic [EW-1:0] r;
    r = s;
    if (r >= EW'(NUM_ROB_ENTS)) r = r - EW'(NUM_ROB_ENTS);
    return TAG_W'(r);
  endfunction

  // Count valid lanes contiguous from lane 0; the first gap ends the group.
  always_comb begin
    logic stop;
    n    = '0;
    stop = 1'b0;
    for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
      if (!stop && disp_valid[i]) n = n + CNT_W'(1);
      else                        stop = 1'b1;
    end
  end

  assign free = OCC_W'(NUM_ROB_ENTS) - occ_q;

  // Readiness looks at registered occupancy only; same-cycle retire does not help,
  // and a flush in the same cycle cancels the group.
  assign disp_ready = rst && (state_q == ROB_RUN) && !flush && (free >= OCC_W'(n));
  assign acc_n      = disp_ready ? n : '0;

  // Per-lane tags and accepted-lane enables.
  always_comb begin
    for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
      disp_tag[i] = wrap_idx(EW'(tail_q) + EW'(i));
      lane_en[i]  = disp_ready && (CNT_W'(i) < n);
    end
  end

  // NUM_ROB_ENTS is a multiple of the power-of-two bank count, so the bank of
  // (tail + i) mod NUM_ROB_ENTS is just the low bits of tail plus i.
  rob_bank_rotate #(
    .DISPATCH_WIDTH (DISPATCH_WIDTH)
  ) u_rotate (
    .rot_i       (tail_q[ROT_W-1:0]),
    .lane_en_i   (lane_en),
    .lane_data_i (disp_entry),
    .bank_en_o   (bank_w_en),
    .bank_data_o (bank_data)
  );

  assign ret_lim = (retire_cnt > CNT_W'(DISPATCH_WIDTH)) ? CNT_W'(DISPATCH_WIDTH) : retire_cnt;
  assign ret_eff = (OCC_W'(ret_lim) > occ_q) ? occ_q : OCC_W'(ret_lim);
  assign head    = wrap_idx(EW'(tail_q) + EW'(NUM_ROB_ENTS) - EW'(occ_q));

  // Next occupancy, tail and control state.
  always_comb begin
    occ_d   = occ_q;
    tail_d  = tail_q;
    state_d = state_q;
    if (flush) begin
      occ_d   = '0;
      tail_d  = head;
      state_d = ROB_FLUSH;
    end else begin
      occ_d  = occ_q + OCC_W'(acc_n) - ret_eff;
      tail_d = wrap_idx(EW'(tail_q) + EW'(acc_n));
      unique case (state_q)
        ROB_RUN:   if (occ_d == OCC_W'(NUM_ROB_ENTS)) state_d = ROB_FULL;
        ROB_FULL:  if (occ_d != OCC_W'(NUM_ROB_ENTS)) state_d = ROB_RUN;
        ROB_FLUSH: state_d = ROB_RUN;
        default:   state_d = ROB_RUN;
      endcase
    end
  end

  // State, tail and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ROB_RUN;
      tail_q  <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
    end
  end

  assign rob_full  = (occ_q == OCC_W'(NUM_ROB_ENTS));
  assign rob_empty = (occ_q == '0);

`ifdef ROB_ALLOC_STATS_EN
  logic [STALL_CNT_BITS-1:0] stall_q, stall_d;

  // Count cycles where lane 0 wants to dispatch but the group is refused; saturate.
  always_comb begin
    stall_d = stall_q;
    if (disp_valid[0] && !disp_ready && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_rob_alloc.sv
// Self-checking bench for rob_alloc: spec-level model feeding a scoreboard, a
// table of hand-derived vectors, and hand sequences for full/flush corners.
module tb_rob_alloc;
  import CORE_PKG::*;

  localparam int DW  = 2;
  localparam int NUM = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [1:0]      disp_valid;
  ROB_Entry [1:0]  disp_entry;
  logic            disp_ready;
  logic [1:0][5:0] disp_tag;
  logic [1:0]      bank_w_en;
  ROB_Entry [1:0]  bank_data;
  logic [1:0]      retire_cnt;
  logic            flush;
  logic            rob_full;
  logic            rob_empty;
`ifdef ROB_ALLOC_STATS_EN
  logic [31:0]     stall_cycles;
`endif

  rob_alloc #(
    .DISPATCH_WIDTH (DW),
    .NUM_ROB_ENTS   (NUM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .disp_valid (disp_valid),
    .disp_entry (disp_entry),
    .disp_ready (disp_ready),
    .disp_tag   (disp_tag),
    .bank_w_en  (bank_w_en),
    .bank_data  (bank_data),
    .retire_cnt (retire_cnt),
    .flush      (flush),
    .rob_full   (rob_full),
    .rob_empty  (rob_empty)
`ifdef ROB_ALLOC_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model state (0=RUN, 1=FULL, 2=FLUSH).
  int          m_occ, m_tail, m_state;
  int          m_occ_n, m_tail_n, m_state_n;
  logic [31:0] m_stall, m_stall_n;

  typedef struct {
    logic       ready;
    logic [1:0] wen;
    int         tag0, tag1;
    ROB_Entry   d0, d1;
    logic       full, empty;
  } exp_t;
  exp_t sbq[$];

  function automatic ROB_Entry rnd_entry();
    ROB_Entry e;
    e.pc  = $urandom;
    e.rd  = 5'($urandom);
    e.exc = 1'($urandom);
    return e;
  endfunction

  // Drive one cycle of stimulus (called just after a rising edge), push the
  // model's expectation, then compare settled outputs against it.
  task automatic drive(input logic [1:0] v, input int ret, input logic fl);
    exp_t e, got;
    int   n, r, acc;
    disp_valid    = v;
    retire_cnt    = 2'(ret);
    flush         = fl;
    disp_entry[0] = rnd_entry();
    disp_entry[1] = rnd_entry();
    n = v[0] ? (v[1] ? 2 : 1) : 0;
    e.ready = (m_state == 0) && !fl && ((NUM - m_occ) >= n);
    e.tag0  = m_tail;
    e.tag1  = (m_tail + 1) % NUM;
    e.wen   = 2'b00;
    e.d0    = '0;
    e.d1    = '0;
    if (e.ready) begin
      for (int i = 0; i < n; i++) begin
        int b;
        b = (m_tail + i) % DW;
        e.wen[b] = 1'b1;
        if (b == 0) e.d0 = disp_entry[i];
        else        e.d1 = disp_entry[i];
      end
    end
    e.full  = (m_occ == NUM);
    e.empty = (m_occ == 0);
    sbq.push_back(e);

    if (fl) begin
      m_occ_n   = 0;
      m_tail_n  = (m_tail - m_occ + NUM) % NUM;
      m_state_n = 2;
    end else begin
      r   = (ret > DW) ? DW : ret;
      if (r > m_occ) r = m_occ;
      acc = e.ready ? n : 0;
      m_occ_n   = m_occ + acc - r;
      m_tail_n  = (m_tail + acc) % NUM;
      m_state_n = (m_state == 2) ? 0 : ((m_occ_n == NUM) ? 1 : 0);
    end
    m_stall_n = (v[0] && !e.ready && (m_stall != '1)) ? m_stall + 1 : m_stall;

    #3;
    got = sbq.pop_front();
    chk("ready", disp_ready, got.ready);
    chk("bank_w_en", bank_w_en, got.wen);
    chk("tag0", disp_tag[0], got.tag0);
    chk("tag1", disp_tag[1], got.tag1);
    if (got.wen[0]) chk("bank0_data", bank_data[0], got.d0);
    if (got.wen[1]) chk("bank1_data", bank_data[1], got.d1);
    chk("rob_full", rob_full, got.full);
    chk("rob_empty", rob_empty, got.empty);
`ifdef ROB_ALLOC_STATS_EN
    chk("stall_cycles", stall_cycles, m_stall);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_occ   = m_occ_n;
    m_tail  = m_tail_n;
    m_state = m_state_n;
    m_stall = m_stall_n;
  endtask

  // Hand-derived expectations for the currently settled cycle.
  task automatic hc(input string nm, input logic er, input logic [1:0] ew, input int t0, input int t1);
    chk({nm, "_ready"}, disp_ready, er);
    chk({nm, "_wen"}, bank_w_en, ew);
    chk({nm, "_tag0"}, disp_tag[0], t0);
    chk({nm, "_tag1"}, disp_tag[1], t1);
  endtask

  // Assert reset with a full group pending; the group must be discarded.
  task automatic do_reset();
    rst        = 1'b0;
    disp_valid = 2'b11;
    retire_cnt = '0;
    flush      = 1'b0;
    disp_entry[0] = rnd_entry();
    disp_entry[1] = rnd_entry();
    #2;
    chk("rst_ready", disp_ready, 1'b0);
    chk("rst_wen", bank_w_en, 2'b00);
    chk("rst_empty", rob_empty, 1'b1);
    chk("rst_full", rob_full, 1'b0);
`ifdef ROB_ALLOC_STATS_EN
    chk("rst_stall", stall_cycles, 32'd0);
`endif
    m_occ = 0; m_tail = 0; m_state = 0; m_stall = '0;
    disp_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] v;
    int         ret;
    logic       fl;
    logic       rdy;
    logic [1:0] wen;
    int         t0, t1;
    logic       empty;
  } vec_t;
  vec_t tbl[9];

  initial begin
    tbl[0] = '{2'b11, 0, 1'b0, 1'b1, 2'b11, 0, 1, 1'b1};
    tbl[1] = '{2'b10, 0, 1'b0, 1'b1, 2'b00, 2, 3, 1'b0};
    tbl[2] = '{2'b01, 0, 1'b0, 1'b1, 2'b01, 2, 3, 1'b0};
    tbl[3] = '{2'b11, 0, 1'b0, 1'b1, 2'b11, 3, 4, 1'b0};
    tbl[4] = '{2'b00, 3, 1'b0, 1'b1, 2'b00, 5, 6, 1'b0};
    tbl[5] = '{2'b11, 2, 1'b0, 1'b1, 2'b11, 5, 6, 1'b0};
    tbl[6] = '{2'b00, 3, 1'b0, 1'b1, 2'b00, 7, 8, 1'b0};
    tbl[7] = '{2'b00, 2, 1'b0, 1'b1, 2'b00, 7, 8, 1'b0};
    tbl[8] = '{2'b00, 0, 1'b0, 1'b1, 2'b00, 7, 8, 1'b1};

    disp_valid = '0;
    retire_cnt = '0;
    flush      = 1'b0;
    disp_entry = '0;

    // Table vectors from reset.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      drive(tbl[k].v, tbl[k].ret, tbl[k].fl);
      hc($sformatf("vec%0d", k), tbl[k].rdy, tbl[k].wen, tbl[k].t0, tbl[k].t1);
      chk($sformatf("vec%0d_empty", k), rob_empty, tbl[k].empty);
      if (k == 3) begin
        chk("vec3_bank1_from_lane0", bank_data[1], disp_entry[0]);
        chk("vec3_bank0_from_lane1", bank_data[0], disp_entry[1]);
      end
      tick();
    end

    // Fill to the last free entry, refuse a pair, accept a single, wrap and go full.
    do_reset();
    for (int k = 0; k < 31; k++) begin drive(2'b11, 0, 1'b0); tick(); end
    drive(2'b01, 0, 1'b0); hc("fill62", 1'b1, 2'b01, 62, 63); tick();
    drive(2'b11, 0, 1'b0); hc("occ63_pair", 1'b0, 2'b00, 63, 0); tick();
    drive(2'b01, 0, 1'b0); hc("occ63_single", 1'b1, 2'b10, 63, 0); tick();
    drive(2'b01, 0, 1'b0); hc("full", 1'b0, 2'b00, 0, 1);
    chk("full_flag", rob_full, 1'b1); tick();
    drive(2'b01, 2, 1'b0); hc("full_retire", 1'b0, 2'b00, 0, 1); tick();
    drive(2'b11, 0, 1'b0); hc("after_retire", 1'b1, 2'b11, 0, 1);
    chk("after_retire_full", rob_full, 1'b0); tick();

    // Flush with a pending group, then flush held for two cycles.
    do_reset();
    for (int k = 0; k < 10; k++) begin drive(2'b11, 0, 1'b0); tick(); end
    for (int k = 0; k < 5; k++)  begin drive(2'b00, 2, 1'b0); tick(); end
    drive(2'b11, 2, 1'b1); hc("flush", 1'b0, 2'b00, 20, 21); tick();
    drive(2'b11, 0, 1'b0); hc("flush_state", 1'b0, 2'b00, 10, 11);
    chk("flush_empty", rob_empty, 1'b1); tick();
    drive(2'b11, 0, 1'b0); hc("post_flush", 1'b1, 2'b11, 10, 11); tick();
    drive(2'b00, 0, 1'b1); tick();
    drive(2'b00, 0, 1'b1); hc("flush_held", 1'b0, 2'b00, 10, 11); tick();
    drive(2'b01, 0, 1'b0); hc("flush_exit", 1'b0, 2'b00, 10, 11); tick();
    drive(2'b01, 0, 1'b0); hc("flush_run", 1'b1, 2'b01, 10, 11); tick();

    // Random traffic against the model, biased to reach full.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      logic [1:0] v;
      v = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) v = 2'b11;
      drive(v, $urandom_range(0, 3), ($urandom_range(0, 19) == 0));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
